// File: rtl/spi_poci_ser_if.sv
// Byte handshake and serial-output bundle between the register-read logic and
// the POCI serializer.
interface spi_poci_ser_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             poci;
    logic             byte_done;
    logic             underrun;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  poci,
        input  byte_done,
        input  underrun
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output poci,
        output byte_done,
        output underrun
    );
endinterface

// File: rtl/spi_poci_ser.sv
// SPI peripheral-side POCI serializer: holding register plus shift register,
// MSB first, every frame opens with FILL and chip select high clears all state.
module spi_poci_ser #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] FILL  = {WIDTH{1'b0}}
) (
    input  logic          spi_clk_i,
    input  logic          rstn_i,
    input  logic          csb_i,
    spi_poci_ser_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             full_rstn_s;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             first_q, first_d;
    logic             byte_done_q, byte_done_d;
    logic             underrun_q, underrun_d;
    logic [WIDTH-1:0] src_s;

    // Deasserted chip select acts exactly like chip reset on the frame state.
    assign full_rstn_s = rstn_i & ~csb_i;

    // Word that the next word start will shift out.
    always_comb begin
        src_s = FILL;
        if (hold_full_q) begin
            src_s = hold_q;
        end else begin
            src_s = FILL;
        end
    end

    // Next-state: load into hold, then word start / mid-word / last bit.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        first_d     = first_q;
        byte_done_d = 1'b0;
        underrun_d  = underrun_q;

        // Loading needs an empty hold, so it can never collide with a consume.
        if (bus.tx_valid && !hold_full_q) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end else begin
            hold_d      = hold_q;
        end

        if (bit_cnt_q == {CW{1'b0}}) begin
            // MSB is already on poci, so the register keeps only the remainder.
            shreg_d   = {src_s[WIDTH-2:0], 1'b0};
            first_d   = 1'b0;
            bit_cnt_d = CW'(1);
            if (hold_full_q) begin
                hold_full_d = 1'b0;
            end else if (!first_q) begin
                underrun_d = 1'b1;
            end else begin
                underrun_d = underrun_q;
            end
        end else if (bit_cnt_q == LAST) begin
            bit_cnt_d   = {CW{1'b0}};
            byte_done_d = 1'b1;
        end else begin
            shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CW'(1);
        end
    end

    // Frame state registers, cleared by chip reset or chip select high.
    always_ff @(posedge spi_clk_i or negedge full_rstn_s) begin
        if (!full_rstn_s) begin
            hold_q      <= {WIDTH{1'b0}};
            hold_full_q <= 1'b0;
            shreg_q     <= {WIDTH{1'b0}};
            bit_cnt_q   <= {CW{1'b0}};
            first_q     <= 1'b1;
            byte_done_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            first_q     <= first_d;
            byte_done_q <= byte_done_d;
            underrun_q  <= underrun_d;
        end
    end

    // poci is decoded from registers only so it settles right after each edge.
    always_comb begin
        bus.poci = shreg_q[WIDTH-1];
        if (bit_cnt_q == {CW{1'b0}}) begin
            bus.poci = src_s[WIDTH-1];
        end else begin
            bus.poci = shreg_q[WIDTH-1];
        end
    end

    assign bus.tx_ready  = ~hold_full_q;
    assign bus.byte_done = byte_done_q;
    assign bus.underrun  = underrun_q;
endmodule

// File: tb/tb_spi_poci_ser.sv
// Self-checking bench for spi_poci_ser: two instances (FILL=00 and FILL=FF) share
// stimulus and are compared per edge against a word-slot reference model.
module tb_spi_poci_ser;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rstn;
    logic csb;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    spi_poci_ser_if #(.WIDTH(W)) if0 ();
    spi_poci_ser_if #(.WIDTH(W)) if1 ();

    assign if1.tx_data  = if0.tx_data;
    assign if1.tx_valid = if0.tx_valid;

    spi_poci_ser #(.WIDTH(W), .FILL(8'h00)) dut0 (
        .spi_clk_i(clk), .rstn_i(rstn), .csb_i(csb), .bus(if0.slave));
    spi_poci_ser #(.WIDTH(W), .FILL(8'hFF)) dut1 (
        .spi_clk_i(clk), .rstn_i(rstn), .csb_i(csb), .bus(if1.slave));

    // Reference model: frame as a sequence of W-edge slots fed from a one-deep holding slot.
    logic [7:0] fill [2];
    int         m_edge;
    bit         m_pend;
    logic [7:0] m_pend_data;
    logic [7:0] m_cur [2];
    bit         m_under [2];
    logic [7:0] acc [2];
    logic [7:0] obs_w0 [$];
    logic [7:0] obs_w1 [$];

    task automatic model_clear();
        m_edge = 0;
        m_pend = 1'b0;
        m_pend_data = 8'h00;
        for (int i = 0; i < 2; i++) begin
            m_cur[i] = 8'h00;
            m_under[i] = 1'b0;
            acc[i] = 8'h00;
        end
        obs_w0.delete();
        obs_w1.delete();
    endtask

    // Called at a falling edge: check pre-edge outputs, drive, clock one rising edge, update model.
    task automatic step_edge(input bit v, input logic [7:0] d);
        int e, idx, k;
        logic [7:0] w;
        logic exp_bit;
        logic obs_poci [2];
        logic obs_rdy [2];
        logic obs_bd [2];
        logic obs_ur [2];
        bit acc_ok;
        e = m_edge + 1;
        idx = (e - 1) % W;
        k = (e - 1) / W;
        obs_poci[0] = if0.poci;      obs_poci[1] = if1.poci;
        obs_rdy[0]  = if0.tx_ready;  obs_rdy[1]  = if1.tx_ready;
        obs_bd[0]   = if0.byte_done; obs_bd[1]   = if1.byte_done;
        obs_ur[0]   = if0.underrun;  obs_ur[1]   = if1.underrun;
        for (int i = 0; i < 2; i++) begin
            w = m_pend ? m_pend_data : fill[i];
            exp_bit = (idx == 0) ? w[W-1] : m_cur[i][W-1-idx];
            tests_run++;
            if (obs_poci[i] !== exp_bit) begin
                tests_failed++;
                $display("FAIL poci dut%0d E%0d: got %b want %b", i, e, obs_poci[i], exp_bit);
            end
            tests_run++;
            if (obs_rdy[i] !== !m_pend) begin
                tests_failed++;
                $display("FAIL tx_ready dut%0d E%0d: got %b want %b", i, e, obs_rdy[i], !m_pend);
            end
            tests_run++;
            if (obs_bd[i] !== (m_edge > 0 && (m_edge % W) == 0)) begin
                tests_failed++;
                $display("FAIL byte_done dut%0d after E%0d: got %b want %b", i, m_edge, obs_bd[i],
                         (m_edge > 0 && (m_edge % W) == 0));
            end
            tests_run++;
            if (obs_ur[i] !== m_under[i]) begin
                tests_failed++;
                $display("FAIL underrun dut%0d after E%0d: got %b want %b", i, m_edge, obs_ur[i], m_under[i]);
            end
            acc[i] = {acc[i][6:0], obs_poci[i]};
        end
        if (idx == W - 1) begin
            obs_w0.push_back(acc[0]);
            obs_w1.push_back(acc[1]);
        end
        if0.tx_valid = v;
        if0.tx_data = d;
        @(posedge clk);
        acc_ok = v && !m_pend;
        if (idx == 0) begin
            for (int i = 0; i < 2; i++) begin
                m_cur[i] = m_pend ? m_pend_data : fill[i];
                if (!m_pend && k > 0) m_under[i] = 1'b1;
            end
            m_pend = 1'b0;
        end
        if (acc_ok) begin
            m_pend = 1'b1;
            m_pend_data = d;
        end
        m_edge = e;
        @(negedge clk);
        if0.tx_valid = 1'b0;
    endtask

    task automatic start_frame();
        csb = 1'b0;
        model_clear();
    endtask

    // Raise chip select and confirm every output returns to its idle value at once.
    task automatic end_frame();
        csb = 1'b1;
        #1;
        tests_run++;
        if (if0.tx_ready !== 1'b1 || if1.tx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort tx_ready: got %b/%b want 1/1", if0.tx_ready, if1.tx_ready);
        end
        tests_run++;
        if (if0.byte_done !== 1'b0 || if1.byte_done !== 1'b0 || if0.underrun !== 1'b0 || if1.underrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort flags: got bd %b/%b ur %b/%b want 0", if0.byte_done, if1.byte_done,
                     if0.underrun, if1.underrun);
        end
        tests_run++;
        if (if0.poci !== 1'b0 || if1.poci !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort poci: got %b/%b want 0/1", if0.poci, if1.poci);
        end
        @(negedge clk);
    endtask

    task automatic run_edges(input int n, input int le0, input logic [7:0] ld0,
                             input int le1, input logic [7:0] ld1);
        for (int e = 1; e <= n; e++) begin
            if (e == le0) step_edge(1'b1, ld0);
            else if (e == le1) step_edge(1'b1, ld1);
            else step_edge(1'b0, 8'($urandom));
        end
    endtask

    task automatic check_words(input string name, input int n, input logic [7:0] e0_0,
                               input logic [7:0] e0_1, input logic [7:0] e0_2,
                               input logic [7:0] e1_0);
        logic [7:0] exp0 [3];
        exp0[0] = e0_0; exp0[1] = e0_1; exp0[2] = e0_2;
        tests_run++;
        if (obs_w0.size() != n || obs_w1.size() != n) begin
            tests_failed++;
            $display("FAIL %s word count: got %0d/%0d want %0d", name, obs_w0.size(), obs_w1.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                tests_run++;
                if (obs_w0[i] !== exp0[i]) begin
                    tests_failed++;
                    $display("FAIL %s dut0 word%0d: got %h want %h", name, i, obs_w0[i], exp0[i]);
                end
                tests_run++;
                if (obs_w1[i] !== ((i == 0) ? e1_0 : ((exp0[i] == 8'h00) ? 8'hFF : exp0[i]))) begin
                    tests_failed++;
                    $display("FAIL %s dut1 word%0d: got %h want %h", name, i, obs_w1[i],
                             ((i == 0) ? e1_0 : ((exp0[i] == 8'h00) ? 8'hFF : exp0[i])));
                end
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        csb = 1'b0;
        if0.tx_valid = 1'b0;
        if0.tx_data = 8'h00;
        #1;
        tests_run++;
        if (if0.tx_ready !== 1'b1 || if0.byte_done !== 1'b0 || if0.underrun !== 1'b0 || if0.poci !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset dut0: got rdy %b bd %b ur %b poci %b want 1 0 0 0",
                     if0.tx_ready, if0.byte_done, if0.underrun, if0.poci);
        end
        tests_run++;
        if (if1.poci !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset dut1 poci: got %b want 1", if1.poci);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        csb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        start_frame();
        run_edges(16, 3, 8'hA5, 0, 8'h00);
        check_words("single", 2, 8'h00, 8'hA5, 8'h00, 8'hFF);
        tests_run++;
        if (if0.byte_done !== 1'b1 || if0.underrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL single end: got bd %b ur %b want 1 0", if0.byte_done, if0.underrun);
        end
        end_frame();
    endtask

    task automatic test_back_to_back();
        start_frame();
        run_edges(24, 2, 8'h3C, 10, 8'hC3);
        check_words("b2b", 3, 8'h00, 8'h3C, 8'hC3, 8'hFF);
        tests_run++;
        if (if0.underrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b underrun: got %b want 0", if0.underrun);
        end
        end_frame();
    endtask

    task automatic test_boundary();
        start_frame();
        run_edges(16, 8, 8'h5A, 0, 8'h00);
        check_words("bound_e8", 2, 8'h00, 8'h5A, 8'h00, 8'hFF);
        end_frame();
        start_frame();
        run_edges(9, 9, 8'h5A, 0, 8'h00);
        tests_run++;
        if (if0.underrun !== 1'b1 || if1.underrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL bound_e9 underrun after E9: got %b/%b want 1/1", if0.underrun, if1.underrun);
        end
        for (int e = 10; e <= 24; e++) step_edge(1'b0, 8'h00);
        check_words("bound_e9", 3, 8'h00, 8'h00, 8'h5A, 8'hFF);
        end_frame();
    endtask

    task automatic test_abort();
        start_frame();
        run_edges(12, 3, 8'hFF, 0, 8'h00);
        end_frame();
        start_frame();
        run_edges(8, 0, 8'h00, 0, 8'h00);
        check_words("abort_next", 1, 8'h00, 8'h00, 8'h00, 8'hFF);
        tests_run++;
        if (if0.underrun !== 1'b0 || if0.byte_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_next end: got ur %b bd %b want 0 1", if0.underrun, if0.byte_done);
        end
        end_frame();
    endtask

    task automatic test_random();
        int n;
        for (int f = 0; f < 20; f++) begin
            start_frame();
            n = $urandom_range(40, 4);
            for (int e = 1; e <= n; e++) step_edge(($urandom % 3) == 0, 8'($urandom));
            tests_run++;
            if (obs_w0.size() != n / W) begin
                tests_failed++;
                $display("FAIL random frame%0d words: got %0d want %0d", f, obs_w0.size(), n / W);
            end
            if (($urandom % 2) == 0) begin
                rstn = 1'b0;
                #1;
                tests_run++;
                if (if0.tx_ready !== 1'b1 || if0.underrun !== 1'b0 || if1.poci !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL random rstn clear: got rdy %b ur %b poci1 %b want 1 0 1",
                             if0.tx_ready, if0.underrun, if1.poci);
                end
                @(negedge clk);
                rstn = 1'b1;
            end
            end_frame();
        end
    endtask

    initial begin
        fill[0] = 8'h00;
        fill[1] = 8'hFF;
        model_clear();
        @(negedge clk);
        test_reset();
        test_single_read();
        test_back_to_back();
        test_boundary();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
